de10_lite_led_dimmer: RTL

Output stage between the 10-bit LED PIO and the DE10-Lite LEDR pins. It takes the PIO's registered LED pattern and applies global PWM brightness plus per-LED blinking before driving the pins. Brightness and blink settings come from a small Avalon-MM slave on the same system bus, with the same zero-wait-state register style as the PIO.

---
 rtl/de10_lite_led_pkg.sv | 26 ++
 rtl/de10_lite_led_dimmer_timebase.sv | 45 ++++
 rtl/de10_lite_led_dimmer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/de10_lite_led_pkg.sv
// de10_lite_led_pkg
// Shared constants for the DE10-Lite LED dimmer: Avalon register addresses,
// register reset values and the PWM comparison helper.
package de10_lite_led_pkg;

    // Avalon register addresses
    localparam logic [1:0] LED_REG_DUTY   = 2'd0;
    localparam logic [1:0] LED_REG_PERIOD = 2'd1;
    localparam logic [1:0] LED_REG_MASK   = 2'd2;
    localparam logic [1:0] LED_REG_STATUS = 2'd3;

    // Register reset values (MASK_RST is sliced to the LED count by its user)
    localparam logic [7:0]  DUTY_RST   = 8'hFF;
    localparam logic [15:0] PERIOD_RST = 16'h0000;
    localparam logic [31:0] MASK_RST   = 32'h0000_0000;

    // Last PWM step of a frame; also the "always on" duty code
    localparam logic [7:0] PWM_MAX = 8'hFF;

    // LED is lit for this PWM step; 0xFF is forced fully on so the
    // comparison never leaves a dark step at full brightness.
    function automatic logic pwm_on_f(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == PWM_MAX) || (cnt < duty);
    endfunction

endpackage

// File: rtl/de10_lite_led_dimmer_timebase.sv
// led_pwm_timebase
// Prescaler and 8-bit PWM step counter.
// Ports:
//   clk, reset_n  : system clock, async active-low reset
//   tick          : prescaler at its last count (one clk per PWM step)
//   pwm_cnt       : current PWM step 0..255
//   frame_end     : last clk of the last PWM step of a frame
module led_pwm_timebase
    import de10_lite_led_pkg::*;
#(
    parameter int PRESCALE = 196
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic [7:0] pwm_cnt,
    output logic       frame_end
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] prescale_r;
    logic [7:0]  pwm_cnt_r;
    logic        tick_s;

    assign tick_s    = (prescale_r == PRESCALE_LAST);
    assign tick      = tick_s;
    assign pwm_cnt   = pwm_cnt_r;
    assign frame_end = tick_s && (pwm_cnt_r == PWM_MAX);

    // Prescaler wraps on tick; PWM step counter advances on tick and wraps 255->0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_r <= 16'h0000;
            pwm_cnt_r  <= 8'h00;
        end else if (tick_s) begin
            prescale_r <= 16'h0000;
            pwm_cnt_r  <= pwm_cnt_r + 8'd1;
        end else begin
            prescale_r <= prescale_r + 16'd1;
            pwm_cnt_r  <= pwm_cnt_r;
        end
    end

endmodule

// File: rtl/de10_lite_led_dimmer.sv
// de10_lite_led_dimmer
// Output stage between the LED PIO and the LEDR pins: global PWM brightness
// plus per-LED blinking, configured through a zero-wait-state Avalon slave.
// Ports:
//   clk, reset_n          : system clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon write side
//   readdata              : Avalon read data, combinational from address
//   led_in                : LED pattern from the PIO
//   led_out               : registered LEDR drive
module de10_lite_led_dimmer
    import de10_lite_led_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 196
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led_out
);

    logic [7:0]       duty_r;
    logic [7:0]       duty_active_r;
    logic [15:0]      period_r;
    logic [WIDTH-1:0] mask_r;
    logic [15:0]      blink_cnt_r;
    logic             blink_phase_r;
    logic [WIDTH-1:0] led_out_r;

    logic             tick_s;
    logic [7:0]       pwm_cnt_s;
    logic             frame_end_s;
    logic             wr_s;
    logic             period_wr_s;
    logic             pwm_on_s;
    logic             unused_ok_s;

    led_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick_s),
        .pwm_cnt   (pwm_cnt_s),
        .frame_end (frame_end_s)
    );

    assign wr_s        = chipselect && !write_n;
    assign period_wr_s = wr_s && (address == LED_REG_PERIOD);
    assign pwm_on_s    = pwm_on_f(pwm_cnt_s, duty_active_r);
    assign led_out     = led_out_r;
    assign unused_ok_s = &{1'b0, tick_s, writedata[31:16]};

    // Avalon register file writes; STATUS is read-only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_r   <= DUTY_RST;
            period_r <= PERIOD_RST;
            mask_r   <= MASK_RST[WIDTH-1:0];
        end else if (wr_s) begin
            case (address)
                LED_REG_DUTY:   duty_r   <= writedata[7:0];
                LED_REG_PERIOD: period_r <= writedata[15:0];
                LED_REG_MASK:   mask_r   <= writedata[WIDTH-1:0];
                default: begin
                    duty_r   <= duty_r;
                    period_r <= period_r;
                    mask_r   <= mask_r;
                end
            endcase
        end else begin
            duty_r   <= duty_r;
            period_r <= period_r;
            mask_r   <= mask_r;
        end
    end

    // Brightness shadow: only frame boundaries pick up DUTY, so a frame never
    // mixes two duty values. A coincident DUTY write lands one frame later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_active_r <= DUTY_RST;
        end else if (frame_end_s) begin
            duty_active_r <= duty_r;
        end else begin
            duty_active_r <= duty_active_r;
        end
    end

    // Blink half-period counter; a PERIOD write restarts it in the "on" phase
    // and wins over a frame boundary on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r   <= 16'h0000;
            blink_phase_r <= 1'b0;
        end else if (period_wr_s || (period_r == 16'h0000)) begin
            blink_cnt_r   <= 16'h0000;
            blink_phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (blink_cnt_r == (period_r - 16'd1)) begin
                blink_cnt_r   <= 16'h0000;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + 16'd1;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // LEDR drive register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out_r <= {WIDTH{1'b0}};
        end else begin
            led_out_r <= led_in & {WIDTH{pwm_on_s}} & ~(mask_r & {WIDTH{blink_phase_r}});
        end
    end

    // Zero-latency read mux
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            LED_REG_DUTY:   readdata = {24'h000000, duty_r};
            LED_REG_PERIOD: readdata = {16'h0000, period_r};
            LED_REG_MASK:   readdata = 32'(mask_r);
            LED_REG_STATUS: readdata = {16'h0000, pwm_cnt_s, 7'h00, blink_phase_r};
            default:        readdata = 32'h0000_0000;
        endcase
    end

endmodule
